dif_butterfly_pe: RTL and testbench
===================================

Name: dif_butterfly_pe

Overview:
Pipelined radix-2 decimation-in-frequency butterfly processing element for the DIF systolic FFT/IFFT array. It computes y0 = a + b and y1 = (a − b)·W on 16-bit complex samples, with an elastic valid/ready pipeline so that columns of the systolic array can stall independently. An inverse mode conjugates the twiddle so the same element serves the IFFT path. Optional per-stage scaling by 1/2 is provided, along with a sticky overflow flag.

Parameters:
DW, 16, data width of each real/imag component (two's complement)
TW_FRAC, 14, fractional bits of twiddle (Q1.14: +1.0 = 16384)
SCALE_EN, 0, 1 = arithmetic shift right by 1 of sum and difference before output/multiply

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  PE accepts beat this cycle
a_re, a_im, b_re, b_im  in  DW each  input samples
tw_re, tw_im  in  DW each  twiddle, Q1.TW_FRAC
inv  in  1  1 = use conj(W), sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
y0_re, y0_im, y1_re, y1_im  out  DW each  results
ovf  out  1  sticky overflow flag
ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, out_valid = 0, ovf = 0, all data registers and outputs = 0.
- Three register stages, each with its own valid bit v1, v2, v3; latency is 3 cycles from accept to out_valid when never stalled.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - Output transferred when out_valid && out_ready.
  - Stage enables: en3 = !v3 || out_ready; en2 = !v2 || en3; en1 = !v1 || en2; in_ready = en1 (combinational from out_ready).
  - A stage loads when its enable is high. Its valid takes the upstream valid; for stage 1 that is in_valid && in_ready.
  - Outputs and out_valid hold stable while out_valid && !out_ready.
  - Full throughput is 1 beat/cycle. Up to 3 beats are held while stalled.
  - No beat is dropped or duplicated, and order is preserved.
- Stage 1:
  - s = a + b and d = a − b in DW+1 bits.
  - If SCALE_EN, s and d are shifted arithmetically right by 1 (floor).
  - The twiddle is registered with inv applied: tw_im_eff = inv ? −tw_im : tw_im. Negating −2^(DW−1) saturates to 2^(DW−1)−1.
- Stage 2:
  - pr = d_re·tw_re − d_im·tw_im_eff and pi = d_re·tw_im_eff + d_im·tw_re, full precision (2·DW+2 bits).
  - s passes through unchanged.
- Stage 3:
  - y1 = pr, pi arithmetically shifted right by TW_FRAC (truncation toward −inf), low DW bits kept (wrap).
  - y0 = s, low DW bits kept (wrap).
- Overflow detection:
  - Set when any result's discarded high bits are not a sign extension of bit DW−1. This covers s (stage 1, after scaling) and the shifted pr/pi (stage 3).
  - Evaluated only on beats that load a stage.
  - ovf stays set until ovf_clr. If ovf_clr and a new overflow occur in the same cycle, the set wins.
- inv and tw travel with their beat; changing them mid-stall does not affect in-flight beats.
- Reset asserted mid-stream discards all in-flight beats immediately, and out_valid drops asynchronously.

Test Plan:
- Basic DIF, SCALE_EN=0:
  - Stimulus: a=(100,50), b=(20,10), W=(16384,0), inv=0, out_ready=1.
  - Required: 3 cycles later y0=(120,60), y1=(80,40), ovf=0.
- −j twiddle and inverse:
  - Stimulus: same a and b, W=(0,−16384).
  - Required: y1=(40,−80). With inv=1 instead, y1=(−40,80).
- Scaling, SCALE_EN=1:
  - Stimulus: a=(100,50), b=(20,10), W=(0,−16384).
  - Required: y0=(60,30), y1=(20,−40).
- Overflow, SCALE_EN=0:
  - Stimulus: a_re=30000, b_re=30000, W=(16384,0).
  - Required: y0_re=−5536 (wrapped), ovf=1 and held. Pulsing ovf_clr gives ovf=0 next cycle.
- Backpressure:
  - Stimulus: stream 6 back-to-back beats (a_re=1..6, b=0, W=(16384,0)); hold out_ready=0 from cycle 2 for 5 cycles.
  - Required: in_ready low once 3 beats are held, out_valid and data stable during the stall. After release, y0_re emits 1..6 in order at 1/cycle with none lost.
- Reset mid-operation:
  - Stimulus: assert rst with 3 beats in flight.
  - Required: out_valid=0 and outputs=0 immediately, in_ready=1 after release, no stale beat emitted.

Source files
------------

// File: rtl/dif_butterfly_pe.sv
// Radix-2 DIF butterfly PE: y0 = a + b, y1 = (a - b) * W, three elastic register stages.
// inv conjugates W for the IFFT path; optional 1/2 scaling; sticky overflow flag.
module dif_butterfly_pe #(
    parameter int DW       = 16,
    parameter int TW_FRAC  = 14,
    parameter int SCALE_EN = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_im,
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    input  logic [DW-1:0] tw_re,
    input  logic [DW-1:0] tw_im,
    input  logic          inv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y0_re,
    output logic [DW-1:0] y0_im,
    output logic [DW-1:0] y1_re,
    output logic [DW-1:0] y1_im,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int unsigned SW = DW + 1;
    localparam int unsigned PW = 2 * DW + 2;
    localparam int unsigned HW = PW - DW + 1;
    localparam logic [DW-1:0] TW_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] TW_MAX = {1'b0, {(DW-1){1'b1}}};

    logic v1, v2, v3;
    logic en1, en2, en3;

    // Elastic enables: a stage may load when empty or when its successor moves.
    always_comb begin
        en3 = !v3 || out_ready;
        en2 = !v2 || en3;
        en1 = !v1 || en2;
    end

    assign in_ready  = en1;
    assign out_valid = v3;

    // Stage 1 arithmetic
    logic signed [SW-1:0] sum_re_c, sum_im_c, dif_re_c, dif_im_c;
    logic signed [SW-1:0] s_re_c, s_im_c, d_re_c, d_im_c;
    logic                 s_ovf_c;
    logic        [DW-1:0] tw_im_eff_c;

    always_comb begin
        sum_re_c = $signed({a_re[DW-1], a_re}) + $signed({b_re[DW-1], b_re});
        sum_im_c = $signed({a_im[DW-1], a_im}) + $signed({b_im[DW-1], b_im});
        dif_re_c = $signed({a_re[DW-1], a_re}) - $signed({b_re[DW-1], b_re});
        dif_im_c = $signed({a_im[DW-1], a_im}) - $signed({b_im[DW-1], b_im});
        if (SCALE_EN != 0) begin
            s_re_c = sum_re_c >>> 1;
            s_im_c = sum_im_c >>> 1;
            d_re_c = dif_re_c >>> 1;
            d_im_c = dif_im_c >>> 1;
        end else begin
            s_re_c = sum_re_c;
            s_im_c = sum_im_c;
            d_re_c = dif_re_c;
            d_im_c = dif_im_c;
        end
        s_ovf_c = (s_re_c[SW-1] != s_re_c[SW-2]) || (s_im_c[SW-1] != s_im_c[SW-2]);
    end

    // Conjugate twiddle; the most negative value saturates instead of wrapping to itself.
    always_comb begin
        tw_im_eff_c = tw_im;
        if (inv) begin
            if (tw_im == TW_MIN) tw_im_eff_c = TW_MAX;
            else                 tw_im_eff_c = -tw_im;
        end
    end

    logic        [DW-1:0] s1_re, s1_im;
    logic signed [SW-1:0] d1_re, d1_im;
    logic signed [DW-1:0] w1_re, w1_im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            s1_re <= '0;
            s1_im <= '0;
            d1_re <= '0;
            d1_im <= '0;
            w1_re <= '0;
            w1_im <= '0;
        end else if (en1) begin
            v1    <= in_valid;
            s1_re <= s_re_c[DW-1:0];
            s1_im <= s_im_c[DW-1:0];
            d1_re <= d_re_c;
            d1_im <= d_im_c;
            w1_re <= tw_re;
            w1_im <= tw_im_eff_c;
        end
    end

    // Stage 2: full-precision complex multiply
    logic signed [PW-1:0] m_rr_c, m_ii_c, m_ri_c, m_ir_c, pr_c, pi_c;

    always_comb begin
        m_rr_c = PW'(d1_re) * PW'(w1_re);
        m_ii_c = PW'(d1_im) * PW'(w1_im);
        m_ri_c = PW'(d1_re) * PW'(w1_im);
        m_ir_c = PW'(d1_im) * PW'(w1_re);
        pr_c   = m_rr_c - m_ii_c;
        pi_c   = m_ri_c + m_ir_c;
    end

    logic        [DW-1:0] s2_re, s2_im;
    logic signed [PW-1:0] p2_re, p2_im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            s2_re <= '0;
            s2_im <= '0;
            p2_re <= '0;
            p2_im <= '0;
        end else if (en2) begin
            v2    <= v1;
            s2_re <= s1_re;
            s2_im <= s1_im;
            p2_re <= pr_c;
            p2_im <= pi_c;
        end
    end

    // Stage 3: drop twiddle fraction (floor) and detect loss of high bits
    logic signed [PW-1:0] q_re_c, q_im_c;
    logic                 p_ovf_c;

    always_comb begin
        q_re_c  = p2_re >>> TW_FRAC;
        q_im_c  = p2_im >>> TW_FRAC;
        p_ovf_c = (q_re_c[PW-1:DW-1] != {HW{q_re_c[DW-1]}}) ||
                  (q_im_c[PW-1:DW-1] != {HW{q_im_c[DW-1]}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3    <= 1'b0;
            y0_re <= '0;
            y0_im <= '0;
            y1_re <= '0;
            y1_im <= '0;
        end else if (en3) begin
            v3    <= v2;
            y0_re <= s2_re;
            y0_im <= s2_im;
            y1_re <= q_re_c[DW-1:0];
            y1_im <= q_im_c[DW-1:0];
        end
    end

    // Sticky overflow; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if ((en1 && in_valid && s_ovf_c) || (en3 && v2 && p_ovf_c)) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dif_butterfly_pe.sv
// Bench for dif_butterfly_pe: an unscaled and a scaled instance share stimulus and are
// compared against an integer reference model through a beat queue.
module tb_dif_butterfly_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, inv, ovf_clr;
    logic [15:0] a_re, a_im, b_re, b_im, tw_re, tw_im;

    logic [1:0]  in_ready_v, out_valid_v, ovf_v;
    logic [15:0] y_v [2][4];

    always #5 clk = ~clk;

    dif_butterfly_pe #(.DW(16), .TW_FRAC(14), .SCALE_EN(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .tw_re(tw_re), .tw_im(tw_im), .inv(inv),
        .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .y0_re(y_v[0][0]), .y0_im(y_v[0][1]), .y1_re(y_v[0][2]), .y1_im(y_v[0][3]),
        .ovf(ovf_v[0]), .ovf_clr(ovf_clr)
    );

    dif_butterfly_pe #(.DW(16), .TW_FRAC(14), .SCALE_EN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .tw_re(tw_re), .tw_im(tw_im), .inv(inv),
        .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .y0_re(y_v[1][0]), .y0_im(y_v[1][1]), .y1_re(y_v[1][2]), .y1_im(y_v[1][3]),
        .ovf(ovf_v[1]), .ovf_clr(ovf_clr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        longint y[2][4];
        bit     ov[2];
    } exp_t;

    function automatic longint floor_div(input longint v, input longint d);
        longint q;
        q = v / d;
        if ((v % d != 0) && (v < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint wrap16(input longint v);
        logic [15:0] t;
        t = v[15:0];
        return longint'($signed(t));
    endfunction

    function automatic bit fits16(input longint v);
        return (v >= -32768) && (v <= 32767);
    endfunction

    function automatic exp_t model(input longint ar, input longint ai, input longint br,
                                   input longint bi, input longint wr, input longint wi,
                                   input bit iv);
        exp_t   e;
        longint wie, sr, si, dr, di, qr, qi;
        wie = iv ? -wi : wi;
        if (wie > 32767) wie = 32767;
        for (int k = 0; k < 2; k++) begin
            sr = ar + br;  si = ai + bi;
            dr = ar - br;  di = ai - bi;
            if (k == 1) begin
                sr = floor_div(sr, 2);  si = floor_div(si, 2);
                dr = floor_div(dr, 2);  di = floor_div(di, 2);
            end
            qr = floor_div(dr * wr - di * wie, 16384);
            qi = floor_div(dr * wie + di * wr, 16384);
            e.y[k][0] = wrap16(sr);
            e.y[k][1] = wrap16(si);
            e.y[k][2] = wrap16(qr);
            e.y[k][3] = wrap16(qi);
            e.ov[k]   = !(fits16(sr) && fits16(si) && fits16(qr) && fits16(qi));
        end
        return e;
    endfunction

    exp_t   q[$];
    int     emit_log[$];
    bit     acc_ov[2];
    bit     seen_ov[2];
    int     acc_total = 0;
    int     emit_total = 0;

    // Scoreboard: transfers sampled mid-cycle take effect at the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            for (int k = 0; k < 2; k++)
                if (!acc_ov[k]) check($sformatf("ovf_quiet_%0d", k), ovf_v[k], 0);
            if (out_valid_v[0] && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    for (int k = 0; k < 2; k++) begin
                        check($sformatf("out_valid_%0d", k), out_valid_v[k], 1);
                        for (int j = 0; j < 4; j++)
                            check($sformatf("y_dut%0d_f%0d", k, j),
                                  longint'($signed(y_v[k][j])), e.y[k][j]);
                        seen_ov[k] = seen_ov[k] | e.ov[k];
                        if (seen_ov[k]) check($sformatf("ovf_sticky_%0d", k), ovf_v[k], 1);
                    end
                    emit_log.push_back(int'($signed(y_v[0][0])));
                    emit_total++;
                end
            end
            if (in_valid && in_ready_v[0]) begin
                e = model(longint'($signed(a_re)), longint'($signed(a_im)),
                          longint'($signed(b_re)), longint'($signed(b_im)),
                          longint'($signed(tw_re)), longint'($signed(tw_im)), inv);
                q.push_back(e);
                acc_total++;
                for (int k = 0; k < 2; k++) acc_ov[k] = acc_ov[k] | e.ov[k];
            end
            if (ovf_clr) begin
                acc_ov  = '{0, 0};
                seen_ov = '{0, 0};
            end
        end
    end

    task automatic clear_model();
        q.delete();
        acc_ov  = '{0, 0};
        seen_ov = '{0, 0};
    endtask

    task automatic set_beat(input int ar, input int ai, input int br, input int bi,
                            input int wr, input int wi, input bit iv);
        a_re = 16'(ar);  a_im = 16'(ai);
        b_re = 16'(br);  b_im = 16'(bi);
        tw_re = 16'(wr); tw_im = 16'(wi);
        inv = iv;
    endtask

    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi, input bit iv);
        bit ok;
        ok = 1'b0;
        set_beat(ar, ai, br, bi, wr, wi, iv);
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready_v[0]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid_v[0]) return;
            @(posedge clk);
            #1;
            lat++;
        end
        lat = 99;
    endtask

    // One beat through both instances with hand-derived expectations.
    task automatic single(input string tag, input int ar, input int ai, input int br,
                          input int bi, input int wr, input int wi, input bit iv,
                          input int e0 [4], input int e1 [4]);
        int lat;
        send(ar, ai, br, bi, wr, wi, iv);
        wait_out(lat);
        check({tag, "_lat"}, lat, 3);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("%s_d0_f%0d", tag, j), longint'($signed(y_v[0][j])), e0[j]);
            check($sformatf("%s_d1_f%0d", tag, j), longint'($signed(y_v[1][j])), e1[j]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        set_beat(0, 0, 0, 0, 0, 0, 1'b0);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid_v[0], 0);
        check("rst_in_ready", in_ready_v[0], 1);
        check("rst_y0_re", y_v[0][0], 0);
        check("rst_y1_im", y_v[0][3], 0);
        check("rst_ovf", ovf_v[0], 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        single("basic", 100, 50, 20, 10, 16384, 0, 1'b0,
               '{120, 60, 80, 40}, '{60, 30, 40, 20});
        check("basic_ovf", ovf_v[0], 0);
        single("mj", 100, 50, 20, 10, 0, -16384, 1'b0,
               '{120, 60, 40, -80}, '{60, 30, 20, -40});
        single("mj_inv", 100, 50, 20, 10, 0, -16384, 1'b1,
               '{120, 60, -40, 80}, '{60, 30, -20, 40});
        single("sat_inv", 0, 2, 0, 0, 0, -32768, 1'b1,
               '{0, 2, -4, 0}, '{0, 1, -2, 0});
        check("sat_ovf", ovf_v[0], 0);

        single("ovf", 30000, 0, 30000, 0, 16384, 0, 1'b0,
               '{-5536, 0, 0, 0}, '{30000, 0, 0, 0});
        check("ovf_set0", ovf_v[0], 1);
        check("ovf_set1", ovf_v[1], 0);
        repeat (4) @(posedge clk);
        #1;
        check("ovf_hold", ovf_v[0], 1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check("ovf_clr", ovf_v[0], 0);

        // Backpressure: six back-to-back beats with a five-cycle downstream stall.
        begin
            int idx;
            idx = 0;
            emit_log.delete();
            for (int c = 0; c < 40; c++) begin
                out_ready = !(c >= 2 && c < 7);
                if (idx < 6) begin
                    set_beat(idx + 1, 0, 0, 0, 16384, 0, 1'b0);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                if (c >= 3 && c < 7) begin
                    check("bp_hold_valid", out_valid_v[0], 1);
                    check("bp_hold_y0", longint'($signed(y_v[0][0])), 1);
                    if (acc_total - emit_total == 3) check("bp_in_ready", in_ready_v[0], 0);
                end
                @(negedge clk);
                if (in_valid && in_ready_v[0]) idx++;
                @(posedge clk);
                #1;
                if (idx == 6 && c > 14) break;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            check("bp_count", emit_log.size(), 6);
            for (int k = 0; k < 6; k++)
                if (k < emit_log.size()) check($sformatf("bp_order_%0d", k), emit_log[k], k + 1);
        end

        // Reset with three beats held in the pipe.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(7 + k, 0, 0, 0, 16384, 0, 1'b0);
        check("rr_full", out_valid_v[0], 1);
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check("rr_out_valid", out_valid_v[0], 0);
        check("rr_y0_re", y_v[0][0], 0);
        check("rr_y1_re", y_v[1][2], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("rr_in_ready", in_ready_v[0], 1);
        repeat (6) @(posedge clk);
        #1;
        check("rr_no_stale", out_valid_v[0], 0);

        // Randomized traffic with random stalls against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            set_beat(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                     int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                     int'($urandom_range(0, 65535)),
                     ($urandom % 8 == 0) ? 32768 : int'($urandom_range(0, 65535)),
                     1'($urandom % 2));
            if ($urandom % 16 == 0) set_beat(int'($urandom_range(0, 200)), 0,
                                             int'($urandom_range(0, 200)), 0, 16384, 0, 1'b0);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
